i2c_word_writer: RTL and testbench
==================================

I2C_WORD_WRITER -- requirements
Module: i2c_word_writer

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 125, meaning clk50 cycles per quarter SCL period (125 gives 100 kHz).
REQ-002 The module SHALL have parameter DEV_ADDR, default 7'h1A, meaning the 7-bit I2C target address.
REQ-003 The module SHALL have port clk50, input, 1 bit, the system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port start, input, 1 bit, which requests a transaction when sampled high while idle.
REQ-006 The module SHALL have port word, input, 16 bits, the configuration word from the upstream config ROM.
REQ-007 The module SHALL have port sda_in, input, 1 bit, the sampled SDA bus level.
REQ-008 The module SHALL have port scl, output, 1 bit, the SCL level (push-pull).
REQ-009 The module SHALL have port sda_oe, output, 1 bit, where 1 pulls SDA low and 0 releases it (open-drain).
REQ-010 The module SHALL have port busy, output, 1 bit, high from start acceptance until done.
REQ-011 The module SHALL have port done, output, 1 bit, a one-cycle pulse at the end of a transaction.
REQ-012 The module SHALL have port inc, output, 1 bit, a one-cycle pulse that advances the upstream ROM address.
REQ-013 The module SHALL have port ack_err, output, 1 bit, a sticky flag meaning the target NACKed.

Function
REQ-014 A free-running quarter tick SHALL fire every CLK_DIV cycles while busy and SHALL be restarted at start acceptance; all bus phases SHALL advance only on the tick.
REQ-015 The states SHALL be IDLE, START, BIT, ACK, STOP and DONE; each bus state SHALL span 4 quarters (q0..q3).
REQ-016 In IDLE, scl=1, sda_oe=0 and busy=0; a start sampled high SHALL latch word, clear ack_err, set busy the next cycle and enter START.
REQ-017 START SHALL run as follows: q0 SCL high with SDA released; q1 SDA low; q2 SDA low; q3 SCL low.
REQ-018 In BIT, SDA SHALL be set at q0 with SCL low, SCL SHALL be high at q1 and q2, and SCL SHALL go low at q3; bits SHALL go MSB first.
REQ-019 The bytes SHALL be sent in the order {DEV_ADDR,1'b0}, then word[15:8], then word[7:0], each followed by one ACK state.
REQ-020 In ACK, SDA SHALL be released and sda_in SHALL be sampled at q2.
REQ-021 STOP SHALL run as follows: q0 SDA low with SCL low; q1 SCL high; q2 SDA released; q3 hold.
REQ-022 DONE SHALL last one cycle: done=1, inc=1 unless ack_err, then return to IDLE with busy=0.
REQ-023 A normal transaction SHALL take 29 bus states, and done SHALL assert exactly 116*CLK_DIV cycles after the start-sampling edge.
REQ-024 A start that arrives while busy SHALL be ignored; the word SHALL be used only from the start-time latch.
REQ-025 start held high continuously SHALL begin a new transaction in the cycle after DONE.
REQ-026 The bit counter SHALL run 7 down to 0 per byte and the byte counter 0 to 2, with no wrap beyond byte 2.

Reset
REQ-027 While reset_n=0 at a rising edge, the outputs SHALL be scl=1, sda_oe=0, busy=0, done=0, inc=0 and ack_err=0.
REQ-028 Reset while reset_n=0 SHALL also force the state to IDLE and zero all counters.
REQ-029 Reset asserted mid-transaction SHALL release the bus on the next edge, with no STOP generated.

Configuration
REQ-030 The macro I2C_ACK_CHECK_EN SHALL control acknowledge checking.
REQ-031 When I2C_ACK_CHECK_EN is defined, sda_in=1 at an ACK q2 SHALL set ack_err, skip the remaining bytes and go to STOP; DONE SHALL then pulse done with inc=0.
REQ-032 When I2C_ACK_CHECK_EN is undefined, ACK SHALL be ignored, ack_err SHALL be tied to 0, and inc SHALL pulse on every DONE.

Verification
REQ-033 The bench SHALL cover this case: CLK_DIV=4, word=16'h1E00, ACK always 0 -> SDA decodes 0x34, 0x1E, 0x00; done and inc pulse 464 cycles after start; ack_err=0.
REQ-034 The bench SHALL cover this case: START/STOP shape -> SDA falls while SCL=1 at start, rises while SCL=1 at stop, and is otherwise stable while SCL=1.
REQ-035 The bench SHALL cover this case: with I2C_ACK_CHECK_EN defined, NACK on the second byte -> STOP follows that ACK, done=1, inc=0, ack_err=1 until the next start.
REQ-036 The bench SHALL cover this case: word changed and start re-pulsed mid-transaction -> frame unchanged and a single done.
REQ-037 The bench SHALL cover this case: reset_n=0 during the byte 1 data phase -> next edge scl=1, sda_oe=0, busy=0; a new start then gives a full correct frame.
REQ-038 The bench SHALL cover this case: start held high for 3 transactions with word 16'h0C00, 16'h0E4A, 16'h1201 -> 3 inc pulses, spaced 465 cycles apart.

Source files
------------

// File: rtl/i2c_word_writer.sv
// Writes a 16-bit configuration word to one I2C target as {addr+W, hi byte, lo byte}.
// Optional I2C_ACK_CHECK_EN: NACK sets a sticky error, skips the remaining bytes and suppresses inc.
module i2c_word_writer #(
  parameter int         CLK_DIV  = 125,
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] word,
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_oe,
  output logic        busy,
  output logic        done,
  output logic        inc,
  output logic        ack_err
);

  localparam int             CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  DIV_TOP = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     qtr, qtr_nxt;
  logic [2:0]     bit_cnt, bit_nxt;
  logic [1:0]     byte_cnt, byte_nxt;
  logic [15:0]    word_q, word_nxt;
  logic [CW-1:0]  div_cnt, div_nxt;
  logic [7:0]     cur_byte;
  logic           tick, accept, nack;
  logic           scl_nxt, oe_nxt;

`ifdef I2C_ACK_CHECK_EN
  logic ack_err_nxt;
  assign nack = ack_err;
`else
  logic unused_sda;
  assign unused_sda = sda_in;
  assign nack       = 1'b0;
  assign ack_err    = 1'b0;
`endif

  assign tick   = (state inside {START, BIT, ACK, STOP}) && (div_cnt == '0);
  // DONE also accepts, so a held start restarts without passing through IDLE
  assign accept = start && (state inside {IDLE, DONE});

  always_comb begin
    state_nxt = state;
    qtr_nxt   = qtr;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    word_nxt  = word_q;
    div_nxt   = div_cnt;
`ifdef I2C_ACK_CHECK_EN
    ack_err_nxt = ack_err;
`endif
    if (accept) begin
      state_nxt = START;
      qtr_nxt   = 2'd0;
      bit_nxt   = 3'd7;
      byte_nxt  = 2'd0;
      word_nxt  = word;
      div_nxt   = DIV_TOP;
`ifdef I2C_ACK_CHECK_EN
      ack_err_nxt = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: ;
        DONE: state_nxt = IDLE;
        default: begin
          div_nxt = tick ? DIV_TOP : div_cnt - CW'(1);
          if (tick) begin
            qtr_nxt = qtr + 2'd1;
`ifdef I2C_ACK_CHECK_EN
            if (state == ACK && qtr == 2'd2 && sda_in) ack_err_nxt = 1'b1;
`endif
            if (qtr == 2'd3) begin
              case (state)
                START: begin
                  state_nxt = BIT;
                  bit_nxt   = 3'd7;
                  byte_nxt  = 2'd0;
                end
                BIT: begin
                  if (bit_cnt == 3'd0) state_nxt = ACK;
                  else bit_nxt = bit_cnt - 3'd1;
                end
                ACK: begin
                  if (nack || byte_cnt == 2'd2) begin
                    state_nxt = STOP;
                  end else begin
                    state_nxt = BIT;
                    byte_nxt  = byte_cnt + 2'd1;
                    bit_nxt   = 3'd7;
                  end
                end
                STOP:    state_nxt = DONE;
                default: state_nxt = IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    case (byte_nxt)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = word_nxt[15:8];
      default: cur_byte = word_nxt[7:0];
    endcase
  end

  // Bus levels are derived from the next state so scl/sda_oe come straight from flops
  always_comb begin
    scl_nxt = 1'b1;
    oe_nxt  = 1'b0;
    case (state_nxt)
      START: begin
        scl_nxt = (qtr_nxt != 2'd3);
        oe_nxt  = (qtr_nxt != 2'd0);
      end
      BIT: begin
        scl_nxt = (qtr_nxt inside {2'd1, 2'd2});
        oe_nxt  = ~cur_byte[bit_nxt];
      end
      ACK: begin
        scl_nxt = (qtr_nxt inside {2'd1, 2'd2});
        oe_nxt  = 1'b0;
      end
      STOP: begin
        scl_nxt = (qtr_nxt != 2'd0);
        oe_nxt  = ~qtr_nxt[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state    <= IDLE;
      qtr      <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      word_q   <= 16'h0000;
      div_cnt  <= '0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      inc      <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
      ack_err  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      qtr      <= qtr_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      word_q   <= word_nxt;
      div_cnt  <= div_nxt;
      scl      <= scl_nxt;
      sda_oe   <= oe_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      inc      <= (state_nxt == DONE) && !nack;
`ifdef I2C_ACK_CHECK_EN
      ack_err  <= ack_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_word_writer.sv
// Directed bench for i2c_word_writer: a bus monitor decodes SDA on SCL rises and acts as an ACKing target.
module tb_i2c_word_writer;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 116 * CLK_DIV;

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] word = 16'h0000;
  logic        sda_in;
  logic        scl, sda_oe, busy, done, inc, ack_err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  i2c_word_writer #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A)) dut (
    .clk50(clk50), .reset_n(reset_n), .start(start), .word(word), .sda_in(sda_in),
    .scl(scl), .sda_oe(sda_oe), .busy(busy), .done(done), .inc(inc), .ack_err(ack_err)
  );

  always #5 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  // bus monitor / target model
  logic       slave_low = 1'b0, prev_scl = 1'b1, prev_line = 1'b1, line_now;
  logic       mon_clear = 1'b0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] rx [0:3];
  int bit_idx = 0, nbytes = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0, inc_cnt = 0;
  int nack_at = -1;

  assign sda_in = (sda_oe || slave_low) ? 1'b0 : 1'b1;

  always @(negedge clk50) begin
    line_now = sda_in;
    if (mon_clear) begin
      bit_idx = 0; nbytes = 0; start_cnt = 0; stop_cnt = 0; done_cnt = 0; inc_cnt = 0;
      slave_low = 1'b0;
      for (int i = 0; i < 4; i++) rx[i] = 8'h00;
    end else begin
      if (done) done_cnt++;
      if (inc) inc_cnt++;
      if (prev_scl && scl && prev_line && !line_now) begin
        start_cnt++; bit_idx = 0; nbytes = 0;
        for (int i = 0; i < 4; i++) rx[i] = 8'h00;
      end
      if (prev_scl && scl && !prev_line && line_now) stop_cnt++;
      if (!prev_scl && scl) begin
        if (bit_idx < 8) begin
          shreg = {shreg[6:0], line_now};
          bit_idx++;
          if (bit_idx == 8 && nbytes < 4) rx[nbytes] = shreg;
        end else begin
          bit_idx = 0;
          nbytes++;
        end
      end
      if (prev_scl && !scl) slave_low = (bit_idx == 8) && (nbytes != nack_at);
    end
    prev_scl  = scl;
    prev_line = line_now;
  end

  task automatic clear_mon();
    @(negedge clk50) mon_clear = 1'b1;
    @(negedge clk50) mon_clear = 1'b0;
  endtask

  task automatic pulse_start(output int edge_no);
    @(negedge clk50);
    start = 1'b1;
    edge_no = cyc + 1;
    @(negedge clk50);
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int n = 0; n < 3000 && dcyc < 0; n++) begin
      @(negedge clk50);
      if (done) dcyc = cyc;
    end
    if (dcyc < 0) begin
      checks++;
      $display("FAIL wait_done: no done within 3000 cycles");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk50);
    checks++; if (scl !== 1'b1)    $display("FAIL reset_scl: got %b want 1", scl);        else passed++;
    checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe);  else passed++;
    checks++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy);      else passed++;
    checks++; if (done !== 1'b0)   $display("FAIL reset_done: got %b want 0", done);      else passed++;
    checks++; if (inc !== 1'b0)    $display("FAIL reset_inc: got %b want 0", inc);        else passed++;
    checks++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err: got %b want 0", ack_err); else passed++;
    @(negedge clk50) reset_n = 1'b1;
  endtask

  task automatic test_frame();
    int e, d;
    clear_mon();
    word = 16'h1E00;
    pulse_start(e);
    checks++; if (busy !== 1'b1) $display("FAIL frame_busy: got %b want 1", busy); else passed++;
    wait_done(d);
    checks++; if (d - e != FRAME) $display("FAIL frame_latency: got %0d want %0d", d - e, FRAME); else passed++;
    checks++; if (inc !== 1'b1)   $display("FAIL frame_inc: got %b want 1", inc);   else passed++;
    checks++; if (rx[0] !== 8'h34) $display("FAIL frame_addr: got %h want 34", rx[0]); else passed++;
    checks++; if (rx[1] !== 8'h1E) $display("FAIL frame_hi: got %h want 1e", rx[1]);   else passed++;
    checks++; if (rx[2] !== 8'h00) $display("FAIL frame_lo: got %h want 00", rx[2]);   else passed++;
    checks++; if (ack_err !== 1'b0) $display("FAIL frame_ack_err: got %b want 0", ack_err); else passed++;
    repeat (5) @(negedge clk50);
    checks++; if (start_cnt != 1) $display("FAIL shape_start: got %0d want 1", start_cnt); else passed++;
    checks++; if (stop_cnt != 1)  $display("FAIL shape_stop: got %0d want 1", stop_cnt);   else passed++;
    checks++; if (nbytes != 3)    $display("FAIL shape_acks: got %0d want 3", nbytes);     else passed++;
    checks++; if (busy !== 1'b0)  $display("FAIL frame_idle: got %b want 0", busy);        else passed++;
    checks++; if (done_cnt != 1 || inc_cnt != 1)
      $display("FAIL frame_pulses: got done=%0d inc=%0d want 1/1", done_cnt, inc_cnt); else passed++;
  endtask

  task automatic test_ack_check();
    int e, d;
    clear_mon();
    nack_at = 1;
    word = 16'hC3A5;
    pulse_start(e);
    wait_done(d);
`ifdef I2C_ACK_CHECK_EN
    checks++; if (d - e != 80 * CLK_DIV) $display("FAIL nack_latency: got %0d want %0d", d - e, 80 * CLK_DIV); else passed++;
    checks++; if (inc !== 1'b0)     $display("FAIL nack_inc: got %b want 0", inc);         else passed++;
    checks++; if (ack_err !== 1'b1) $display("FAIL nack_ack_err: got %b want 1", ack_err); else passed++;
    checks++; if (nbytes != 2)      $display("FAIL nack_bytes: got %0d want 2", nbytes);   else passed++;
    checks++; if (stop_cnt != 1)    $display("FAIL nack_stop: got %0d want 1", stop_cnt);  else passed++;
    repeat (20) @(negedge clk50);
    checks++; if (ack_err !== 1'b1) $display("FAIL nack_sticky: got %b want 1", ack_err);  else passed++;
    nack_at = -1;
    pulse_start(e);
    checks++; if (ack_err !== 1'b0) $display("FAIL nack_clear: got %b want 0", ack_err);   else passed++;
    wait_done(d);
    checks++; if (inc !== 1'b1)     $display("FAIL nack_recover_inc: got %b want 1", inc); else passed++;
`else
    checks++; if (d - e != FRAME)   $display("FAIL noack_latency: got %0d want %0d", d - e, FRAME); else passed++;
    checks++; if (inc !== 1'b1)     $display("FAIL noack_inc: got %b want 1", inc);        else passed++;
    checks++; if (ack_err !== 1'b0) $display("FAIL noack_ack_err: got %b want 0", ack_err); else passed++;
    checks++; if (rx[2] !== 8'hA5)  $display("FAIL noack_lo: got %h want a5", rx[2]);      else passed++;
    nack_at = -1;
`endif
    repeat (5) @(negedge clk50);
  endtask

  task automatic test_ignore_restart();
    int e, dummy, d;
    clear_mon();
    word = 16'hA55A;
    pulse_start(e);
    repeat (100) @(negedge clk50);
    word = 16'hFFFF;
    pulse_start(dummy);
    word = 16'h0000;
    wait_done(d);
    checks++; if (d - e != FRAME)  $display("FAIL restart_latency: got %0d want %0d", d - e, FRAME); else passed++;
    checks++; if (rx[1] !== 8'hA5) $display("FAIL restart_hi: got %h want a5", rx[1]); else passed++;
    checks++; if (rx[2] !== 8'h5A) $display("FAIL restart_lo: got %h want 5a", rx[2]); else passed++;
    repeat (FRAME + 40) @(negedge clk50);
    checks++; if (done_cnt != 1)   $display("FAIL restart_single_done: got %0d want 1", done_cnt); else passed++;
    checks++; if (busy !== 1'b0)   $display("FAIL restart_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int e, d;
    clear_mon();
    word = 16'h1234;
    pulse_start(e);
    repeat (200) @(negedge clk50);
    reset_n = 1'b0;
    @(negedge clk50);
    checks++; if (scl !== 1'b1)    $display("FAIL midrst_scl: got %b want 1", scl);       else passed++;
    checks++; if (sda_oe !== 1'b0) $display("FAIL midrst_sda_oe: got %b want 0", sda_oe); else passed++;
    checks++; if (busy !== 1'b0)   $display("FAIL midrst_busy: got %b want 0", busy);     else passed++;
    repeat (2) @(negedge clk50);
    reset_n = 1'b1;
    clear_mon();
    word = 16'h5678;
    pulse_start(e);
    wait_done(d);
    checks++; if (d - e != FRAME)  $display("FAIL midrst_latency: got %0d want %0d", d - e, FRAME); else passed++;
    checks++; if (rx[0] !== 8'h34 || rx[1] !== 8'h56 || rx[2] !== 8'h78)
      $display("FAIL midrst_frame: got %h %h %h want 34 56 78", rx[0], rx[1], rx[2]); else passed++;
    checks++; if (start_cnt != 1 || stop_cnt != 1)
      $display("FAIL midrst_shape: got start=%0d stop=%0d want 1/1", start_cnt, stop_cnt); else passed++;
    repeat (5) @(negedge clk50);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [0:2];
    int t [0:2];
    int e;
    words[0] = 16'h0C00; words[1] = 16'h0E4A; words[2] = 16'h1201;
    clear_mon();
    @(negedge clk50);
    word = words[0];
    start = 1'b1;
    e = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      t[i] = -1;
      for (int n = 0; n < 3000 && t[i] < 0; n++) begin
        @(negedge clk50);
        if (inc) t[i] = cyc;
      end
      checks++; if (t[i] < 0) $display("FAIL b2b_wait: no inc for frame %0d", i); else passed++;
      checks++; if ({rx[1], rx[2]} !== words[i])
        $display("FAIL b2b_word: frame %0d got %h%h want %h", i, rx[1], rx[2], words[i]); else passed++;
      if (i < 2) word = words[i + 1];
      else start = 1'b0;
    end
    checks++; if (t[0] - e != FRAME)  $display("FAIL b2b_first: got %0d want %0d", t[0] - e, FRAME); else passed++;
    checks++; if (t[1] - t[0] != 465) $display("FAIL b2b_gap1: got %0d want 465", t[1] - t[0]); else passed++;
    checks++; if (t[2] - t[1] != 465) $display("FAIL b2b_gap2: got %0d want 465", t[2] - t[1]); else passed++;
    repeat (10) @(negedge clk50);
    checks++; if (inc_cnt != 3) $display("FAIL b2b_inc_count: got %0d want 3", inc_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ack_check();
    test_ignore_restart();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
